// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : shared state encodings, width helpers and tag builder |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package uart_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   // Index width that stays legal for a single-entry range.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must hold values 0..max_count inclusive.
   function automatic int count_width(input int max_count);
      return (max_count > 0) ? $clog2(max_count + 1) : 1;
   endfunction

   // Tag word is the requester index zero-extended; callers truncate to WORD_LEN.
   function automatic logic [63:0] tag_word(input int unsigned idx);
      return 64'(idx);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rr_pick : rotate-priority picker, search starts at last+1   |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
module uart_rr_pick
   import uart_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] valid_i,
   input  logic [IDX_W-1:0] last_i,
   output logic             found_o,
   output logic [IDX_W-1:0] winner_o
);

   localparam logic [IDX_W:0] c_N = (IDX_W + 1)'(N_REQ);

   logic [IDX_W:0] w_sum;

   // Walk offsets from farthest to nearest so the nearest valid entry is written last.
   always_comb begin
      found_o  = 1'b0;
      winner_o = '0;
      w_sum    = '0;
      for (int off = N_REQ; off >= 1; off--) begin
         w_sum = {1'b0, last_i} + (IDX_W + 1)'(off);
         if (w_sum >= c_N) begin
            w_sum = w_sum - c_N;
         end
         if (valid_i[w_sum[IDX_W-1:0]]) begin
            found_o  = 1'b1;
            winner_o = w_sum[IDX_W-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin sharing of one multi-word UART TX  |
// |                   with requester tagging and a frame watchdog    |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int WORD_LEN      = 8,
   parameter int PAYLOAD_WORDS = 3,
   parameter int TIMEOUT       = 65535
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic [N_REQ-1:0]                        req_valid_i,
   input  logic [N_REQ*PAYLOAD_WORDS*WORD_LEN-1:0] req_data_i,
   output logic [N_REQ-1:0]                        req_ready_o,
   output logic                                    uart_start_o,
   output logic [(PAYLOAD_WORDS+1)*WORD_LEN-1:0]   uart_data_o,
   input  logic                                    uart_done_i,
   input  logic                                    uart_busy_i,
   output logic [$clog2(N_REQ)-1:0]                grant_o,
   output logic                                    busy_o,
   output logic                                    timeout_o
);

   localparam int c_FRAME_WORDS = PAYLOAD_WORDS + 1;
   localparam int c_PAY_W       = PAYLOAD_WORDS * WORD_LEN;
   localparam int c_FRAME_W     = c_FRAME_WORDS * WORD_LEN;
   localparam int c_IDX_W       = $clog2(N_REQ);
   localparam int c_CNT_W       = count_width(c_FRAME_WORDS);
   localparam int c_WD_W        = count_width(TIMEOUT);

   localparam logic [c_CNT_W-1:0] c_FRAME_CNT = c_CNT_W'(c_FRAME_WORDS);
   localparam logic [c_WD_W-1:0]  c_WD_LAST   = c_WD_W'(TIMEOUT - 1);
   localparam logic [c_IDX_W-1:0] c_LAST_RST  = c_IDX_W'(N_REQ - 1);

   logic [1:0]           r_state;
   logic [c_IDX_W-1:0]   r_last;
   logic [c_IDX_W-1:0]   r_grant;
   logic [c_FRAME_W-1:0] r_data;
   logic                 r_busy;
   logic                 r_timeout;
   logic                 r_done_q;
   logic [c_CNT_W-1:0]   r_word_cnt;
   logic [c_WD_W-1:0]    r_wdog;

   logic                 w_found;
   logic [c_IDX_W-1:0]   w_winner;
   logic [WORD_LEN-1:0]  w_tag;
   logic                 w_done_rise;
   logic                 w_frame_done;
   logic                 w_unused_busy;
   logic [c_PAY_W-1:0]   w_payload [N_REQ];

   for (genvar k = 0; k < N_REQ; k++) begin : g_slice
      assign w_payload[k] = req_data_i[k*c_PAY_W +: c_PAY_W];
   end

   uart_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (c_IDX_W)
   ) u_pick (
      .valid_i  (req_valid_i),
      .last_i   (r_last),
      .found_o  (w_found),
      .winner_o (w_winner)
   );

   assign w_tag        = WORD_LEN'(tag_word(32'(w_winner)));
   assign w_done_rise  = uart_done_i & ~r_done_q;
   assign w_frame_done = (r_word_cnt == c_FRAME_CNT) && !uart_done_i;

   // Completion is tracked from done edges alone; the transmitter busy level is not needed.
   assign w_unused_busy = uart_busy_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_last     <= c_LAST_RST;
         r_grant    <= '0;
         r_data     <= '0;
         r_busy     <= 1'b0;
         r_timeout  <= 1'b0;
         r_done_q   <= 1'b0;
         r_word_cnt <= '0;
         r_wdog     <= '0;
      end else begin
         r_done_q <= uart_done_i;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_data  <= {w_tag, w_payload[w_winner]};
                  r_grant <= w_winner;
                  r_last  <= w_winner;
                  r_busy  <= 1'b1;
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_word_cnt <= '0;
               r_wdog     <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               // A frame that completes on the watchdog's last cycle is not an abort.
               if (w_frame_done) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (r_wdog == c_WD_LAST) begin
                  r_timeout <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
                  if (w_done_rise && (r_word_cnt != c_FRAME_CNT)) begin
                     r_word_cnt <= r_word_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready_o  = (r_state == S_IDLE && w_found) ? (N_REQ'(1) << w_winner) : '0;
   assign uart_start_o = (r_state == S_START);
   assign uart_data_o  = r_data;
   assign grant_o      = r_grant;
   assign busy_o       = r_busy;
   assign timeout_o    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_tx_arbiter : randomized bench with a frame-level model   |
// | Revision           : 1.0                                         |
// +------------------------------------------------------------------+
module tb_uart_tx_arbiter;

   localparam int N    = 4;
   localparam int WL   = 8;
   localparam int PW   = 3;
   localparam int FW   = PW + 1;
   localparam int TO   = 100;
   localparam int PAYW = PW * WL;
   localparam int FRW  = FW * WL;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic [N-1:0]    req_valid_i = '0;
   logic [N*PAYW-1:0] req_data_i = '0;
   logic [N-1:0]    req_ready_o;
   logic            uart_start_o;
   logic [FRW-1:0]  uart_data_o;
   logic            uart_done_i = 1'b0;
   logic            uart_busy_i = 1'b0;
   logic [1:0]      grant_o;
   logic            busy_o;
   logic            timeout_o;

   always #5 clk_i = ~clk_i;

   uart_tx_arbiter #(
      .N_REQ         (N),
      .WORD_LEN      (WL),
      .PAYLOAD_WORDS (PW),
      .TIMEOUT       (TO)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_data_i   (req_data_i),
      .req_ready_o  (req_ready_o),
      .uart_start_o (uart_start_o),
      .uart_data_o  (uart_data_o),
      .uart_done_i  (uart_done_i),
      .uart_busy_i  (uart_busy_i),
      .grant_o      (grant_o),
      .busy_o       (busy_o),
      .timeout_o    (timeout_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   // m_phase: 0 = arbitrating, 1 = start pulse cycle, 2 = frame on the line
   int             m_phase = 0;
   int             m_last = N - 1;
   int             m_grant = 0;
   int             m_words = 0;
   int             m_waited = 0;
   logic [FRW-1:0] m_frame = '0;
   bit             m_busy = 0;
   bit             m_timeout = 0;
   bit             m_prev_done = 0;
   int             m_win;
   logic [N-1:0]   m_ready;

   function automatic int pick(input logic [N-1:0] v, input int last);
      for (int off = 1; off <= N; off++) begin
         if (v[(last + off) % N]) return (last + off) % N;
      end
      return -1;
   endfunction

   always_comb m_win = pick(req_valid_i, m_last);
   always_comb m_ready = (m_phase == 0 && m_win >= 0) ? N'(1 << m_win) : '0;

   always @(posedge clk_i) begin
      if (!rst_ni) begin
         m_phase <= 0; m_last <= N - 1; m_grant <= 0; m_words <= 0; m_waited <= 0;
         m_frame <= '0; m_busy <= 0; m_timeout <= 0; m_prev_done <= 0;
      end else begin
         m_prev_done <= uart_done_i;
         if (m_phase == 0) begin
            if (m_win >= 0) begin
               m_frame <= {8'(m_win), req_data_i[m_win*PAYW +: PAYW]};
               m_grant <= m_win;
               m_last  <= m_win;
               m_busy  <= 1;
               m_phase <= 1;
            end
         end else if (m_phase == 1) begin
            m_words <= 0; m_waited <= 0; m_phase <= 2;
         end else begin
            if (m_words == FW && !uart_done_i) begin
               m_busy <= 0; m_phase <= 0;
            end else if (m_waited + 1 == TO) begin
               m_timeout <= 1; m_busy <= 0; m_phase <= 0;
            end else begin
               m_waited <= m_waited + 1;
               if (uart_done_i && !m_prev_done) m_words <= m_words + 1;
            end
         end
      end
   end

   bit cmp_en = 0;
   always @(negedge clk_i) begin
      if (cmp_en) begin
         check("ready",   req_ready_o,  m_ready);
         check("start",   uart_start_o, (m_phase == 1));
         check("data",    uart_data_o,  m_frame);
         check("grant",   grant_o,      m_grant);
         check("busy",    busy_o,       m_busy);
         check("timeout", timeout_o,    m_timeout);
      end
   end

   // ---------------- transmitter stand-in ----------------
   int tx_left = 0, tx_gap = 0, tx_hold = 0;
   bit tx_stuck = 0;
   always @(posedge clk_i) begin
      bit rst_seen;
      rst_seen = rst_ni;
      #1;
      if (!rst_seen) begin
         tx_left = 0; tx_gap = 0; tx_hold = 0;
      end else if (uart_start_o) begin
         tx_left = FW; tx_gap = $urandom_range(1, 4); tx_hold = 0;
      end else if (tx_hold > 0) begin
         tx_hold--;
         if (tx_hold == 0 && tx_left > 0) tx_gap = $urandom_range(1, 4);
      end else if (tx_left > 0) begin
         if (tx_gap > 0) tx_gap--;
         else begin tx_hold = $urandom_range(1, 3); tx_left--; end
      end
      uart_done_i = (tx_hold > 0) && !tx_stuck;
      uart_busy_i = (tx_left > 0) || (tx_hold > 0);
   end

   logic [N-1:0] ready_seen = '0;
   always @(negedge clk_i) ready_seen <= req_ready_o;

   task automatic step();
      @(posedge clk_i); #1;
   endtask

   task automatic wait_idle(input string name);
      int cyc;
      for (cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk_i);
         if (!busy_o && !uart_start_o) break;
      end
      if (cyc == 400) check({name, "_timeout"}, 0, 1);
      step();
   endtask

   function automatic int idx_of(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   initial begin
      int got[5];
      int n_acc, cnt, rises, starts, cyc;
      bit prev;

      // reset
      rst_ni = 1'b0;
      step(); cmp_en = 1;
      step(); step();
      check("rst_ready", req_ready_o, 0);
      check("rst_start", uart_start_o, 0);
      check("rst_data", uart_data_o, 0);
      check("rst_grant", grant_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_timeout", timeout_o, 0);
      rst_ni = 1'b1;
      step();

      // single request from requester 2
      for (int k = 0; k < N; k++) req_data_i[k*PAYW +: PAYW] = PAYW'($urandom);
      req_data_i[2*PAYW +: PAYW] = 24'hA1B2C3;
      req_valid_i = 4'b0100;
      @(negedge clk_i);
      check("single_ready", req_ready_o, 4'b0100);
      step();
      req_valid_i = '0;
      check("single_start", uart_start_o, 1);
      check("single_data", uart_data_o, 32'h02A1B2C3);
      check("single_grant", grant_o, 2);
      check("single_busy", busy_o, 1);
      check("model_frame", m_frame, 32'h02A1B2C3);
      check("model_grant", m_grant, 2);
      rises = 0; starts = 0; prev = 0;
      for (cyc = 0; cyc < 200; cyc++) begin
         @(negedge clk_i);
         if (uart_done_i && !prev) rises++;
         prev = uart_done_i;
         if (uart_start_o) starts++;
         if (!busy_o) break;
      end
      check("single_end_in_time", (cyc < 200), 1);
      check("single_rises", rises, 4);
      check("single_starts", starts, 1);
      step();

      // all four continuously valid from reset
      rst_ni = 1'b0; step(); rst_ni = 1'b1;
      req_valid_i = 4'hF;
      n_acc = 0;
      for (cyc = 0; cyc < 800 && n_acc < 5; cyc++) begin
         @(negedge clk_i);
         cnt = -1;
         if (req_ready_o != 0) begin
            cnt = idx_of(req_ready_o);
            got[n_acc] = cnt;
            n_acc++;
         end
         step();
         if (cnt >= 0) req_data_i[cnt*PAYW +: PAYW] = PAYW'($urandom);
      end
      req_valid_i = '0;
      check("rr_count", n_acc, 5);
      for (int i = 0; i < 5; i++) check($sformatf("rr_grant%0d", i), got[i], i % N);
      wait_idle("rr_idle");

      // stuck transmitter: watchdog abort
      tx_stuck = 1;
      req_valid_i = 4'b0010;
      @(negedge clk_i);
      check("stuck_ready", req_ready_o, 4'b0010);
      step();
      req_valid_i = '0;
      @(negedge clk_i);
      check("stuck_start", uart_start_o, 1);
      for (cnt = 0; cnt < 300; ) begin
         @(negedge clk_i);
         cnt++;
         if (timeout_o) break;
      end
      check("stuck_cycles", cnt, TO + 1);
      check("stuck_busy", busy_o, 0);
      step();
      tx_stuck = 0;
      req_valid_i = 4'b1000;
      @(negedge clk_i);
      check("after_abort_ready", req_ready_o, 4'b1000);
      check("timeout_sticky", timeout_o, 1);
      step();
      req_valid_i = '0;
      wait_idle("abort_idle");

      // reset in the middle of a frame
      req_valid_i = 4'b0001;
      @(negedge clk_i);
      check("mid_ready", req_ready_o, 4'b0001);
      step();
      req_valid_i = '0;
      rises = 0; prev = 0;
      for (cyc = 0; cyc < 200 && rises < 2; cyc++) begin
         @(negedge clk_i);
         if (uart_done_i && !prev) rises++;
         prev = uart_done_i;
      end
      check("mid_rises", rises, 2);
      step();
      rst_ni = 1'b0;
      step();
      check("mid_rst_start", uart_start_o, 0);
      check("mid_rst_data", uart_data_o, 0);
      check("mid_rst_grant", grant_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_timeout", timeout_o, 0);
      rst_ni = 1'b1;
      req_valid_i = 4'hF;
      @(negedge clk_i);
      check("mid_rst_first", req_ready_o, 4'b0001);
      step();

      // randomized traffic with drops, stalls and occasional resets
      for (cyc = 0; cyc < 3000; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (req_valid_i[k] && ready_seen[k]) begin
               if ($urandom_range(0, 1) == 0) req_valid_i[k] = 1'b0;
               req_data_i[k*PAYW +: PAYW] = PAYW'($urandom);
            end else if (req_valid_i[k]) begin
               if ($urandom_range(0, 19) == 0) req_valid_i[k] = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
               req_valid_i[k] = 1'b1;
               req_data_i[k*PAYW +: PAYW] = PAYW'($urandom);
            end
         end
         tx_stuck = ((cyc % 1000) >= 850);
         if (!rst_ni) rst_ni = 1'b1;
         else if ($urandom_range(0, 499) == 0) rst_ni = 1'b0;
         step();
      end
      req_valid_i = '0;
      tx_stuck = 0;
      rst_ni = 1'b1;
      repeat (TO + 20) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares a single multi-word UART transmitter among N_REQ requesters, e.g. the per-oscillator frequency counters. It accepts one payload per grant, prepends a one-word requester tag, drives the transmitter's start/data inputs and tracks word completions until the whole frame has left the line. A watchdog aborts a frame the transmitter never completes.

## Interface
- N_REQ, 4: number of requesters, 2..16.
- WORD_LEN, 8: UART word width; must equal the transmitter's WORD_LEN.
- PAYLOAD_WORDS, 3: payload words per request; FRAME_WORDS = PAYLOAD_WORDS+1. The transmitter's WORD_COUNT must equal FRAME_WORDS.
- TIMEOUT, 65535: maximum cycles spent in S_WAIT before abort; must be ≥ 1.

- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- req_valid_i  in  N_REQ  per-requester payload valid; must be held with data until accepted.
- req_data_i  in  N_REQ*PAYLOAD_WORDS*WORD_LEN  payloads; requester k occupies slice k.
- req_ready_o  out  N_REQ  one-hot accept pulse; transfer when valid&ready.
- uart_start_o  out  1  one-cycle start pulse to the transmitter.
- uart_data_o  out  FRAME_WORDS*WORD_LEN  frame; top word = tag, below = payload MSW first.
- uart_done_i  in  1  transmitter per-word done flag (level, may span several cycles).
- uart_busy_i  in  1  transmitter busy.
- grant_o  out  clog2(N_REQ)  index of requester currently owning the UART.
- busy_o  out  1  high from accept until frame complete or abort.
- timeout_o  out  1  sticky abort flag; cleared only by reset.

## Operation
- States: S_IDLE, S_START, S_WAIT.
- S_IDLE: if any req_valid_i, pick winner g by searching from (last+1) mod N_REQ upward with wrap; pulse req_ready_o[g], latch uart_data_o = {tag(g), req_data_i slice g}, grant_o = g, last = g, busy_o = 1; go S_START. No valid: stay.
- Tag word = g zero-extended to WORD_LEN.
- S_START: uart_start_o = 1 for exactly this cycle; clear word counter and watchdog; go S_WAIT.
- S_WAIT: count rising edges of uart_done_i (registered previous value). When count == FRAME_WORDS and uart_done_i == 0: busy_o = 0, go S_IDLE. Watchdog increments every S_WAIT cycle; on reaching TIMEOUT: set timeout_o, busy_o = 0, go S_IDLE without further counting.
- uart_data_o and grant_o hold their value from accept until the next accept.
- Requests arriving or dropping during S_START/S_WAIT are ignored; a dropped valid without ready is not a transfer.
- Only one req_ready_o bit is ever high; never two accepts without an intervening frame completion or abort.
- Word counter width clog2(FRAME_WORDS+1); saturates, never wraps.

## Timing
- Reset values: req_ready_o = 0, uart_start_o = 0, uart_data_o = 0, grant_o = 0, busy_o = 0, timeout_o = 0, last = N_REQ-1 (requester 0 wins first), state S_IDLE, done edge register 0.
- Reset is synchronous; asserting rst_ni low mid-frame returns all state to reset values on the next edge; the transmitter shares the reset.
- Accept latency: valid high in S_IDLE → req_ready_o in the same cycle (combinational from state and valid, registered data capture).
- uart_start_o one cycle after accept; frame complete detected the first cycle after the FRAME_WORDS-th done falls.
- Minimum gap between consecutive accepts: 1 idle cycle after completion (S_IDLE arbitration cycle).
- Simultaneous requests: strict round-robin; each of N_REQ continuously-valid requesters is served once per N_REQ frames.

## Structure
- Shared package uart_pkg: state encoding localparams, tag-word construction function, clog2-based width localparams used by uart_tx and this block.
- One sub-module: uart_rr_pick (combinational rotate-priority picker: inputs valid vector and last index, outputs found flag and winner index).

## Test plan
- Single request: req 2 valid with payload 0x A1B2C3 → ready pulse on bit 2, uart_data_o = 0x02A1B2C3, one start pulse, busy_o falls after 4th done edge.
- All four valid continuously → grants 0,1,2,3,0 in order, no back-to-back accepts without completion.
- Stuck UART (uart_done_i tied 0), TIMEOUT = 100 → timeout_o rises exactly 100 cycles into S_WAIT, busy_o falls, next request accepted.
- Long done pulses (STOP = 2 transmitter, done high multiple cycles) → counted once each; frame ends after exactly 4 edges.
- rst_ni low during S_WAIT of word 2 → all outputs at reset values next cycle; next arbitration starts from requester 0.
- Requester drops valid during S_WAIT, reasserts later → no ready seen while dropped; served on its next round-robin turn.
